// File: rtl/spi_master_axis.sv
// SPI mode-0 master: one byte per frame from a valid/ready stream, received byte out as a one-cycle pulse.
// Pins are exposed as I/O/T triplets; T=1 means high-Z.
module spi_master_axis #(
    parameter int CLK_RATIO = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spi_tx_data,
    input  logic       spi_tx_valid,
    output logic       spi_tx_ready,
    output logic [7:0] spi_rx_data,
    output logic       spi_rx_valid,
    input  logic       SCK_I,
    output logic       SCK_O,
    output logic       SCK_T,
    input  logic       SS_I,
    output logic       SS_O,
    output logic       SS_T,
    input  logic       IO0_I,
    output logic       IO0_O,
    output logic       IO0_T,
    input  logic       IO1_I,
    output logic       IO1_O,
    output logic       IO1_T
);
    localparam int CNT_W = (CLK_RATIO > 1) ? $clog2(CLK_RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_RATIO - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_tx, w_tx_nxt;
    logic [7:0]       r_rx, w_rx_nxt;
    logic             r_loaded, w_loaded_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_sck, w_sck_nxt;
    logic             r_ss, w_ss_nxt;
    logic             r_io0, w_io0_nxt;
    logic [7:0]       r_rx_data, w_rx_data_nxt;
    logic             r_rx_valid, w_rx_valid_nxt;
    logic             w_cnt_done;
    logic             w_unused;

    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign w_unused   = SCK_I ^ SS_I ^ IO0_I;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_loaded   <= 1'b0;
            r_ready    <= 1'b0;
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_io0      <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_loaded   <= w_loaded_nxt;
            r_ready    <= w_ready_nxt;
            r_sck      <= w_sck_nxt;
            r_ss       <= w_ss_nxt;
            r_io0      <= w_io0_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_nxt      = r_bit;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_loaded_nxt   = r_loaded;
        w_ready_nxt    = r_ready;
        w_sck_nxt      = r_sck;
        w_ss_nxt       = r_ss;
        w_io0_nxt      = r_io0;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                // A latched byte spends one cycle in IDLE with ready low before SS falls.
                if (r_loaded) begin
                    w_ss_nxt     = 1'b0;
                    w_io0_nxt    = r_tx[7];
                    w_loaded_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = LEAD;
                end else if (r_ready && spi_tx_valid) begin
                    w_tx_nxt     = spi_tx_data;
                    w_ready_nxt  = 1'b0;
                    w_loaded_nxt = 1'b1;
                end else begin
                    w_ready_nxt  = 1'b1;
                end
            end

            LEAD: begin
                if (w_cnt_done) begin
                    w_cnt_nxt   = '0;
                    w_sck_nxt   = 1'b1;
                    w_rx_nxt    = {r_rx[6:0], IO1_I};
                    w_bit_nxt   = '0;
                    w_state_nxt = SHIFT;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (r_sck) begin
                    w_cnt_nxt = '0;
                    w_sck_nxt = 1'b0;
                    if (r_bit != 3'd7) begin
                        w_tx_nxt  = {r_tx[6:0], 1'b0};
                        w_io0_nxt = r_tx[6];
                    end
                end else if (r_bit == 3'd7) begin
                    // Eighth low phase doubles as SS hold; frame closes here.
                    w_cnt_nxt      = '0;
                    w_ss_nxt       = 1'b1;
                    w_rx_data_nxt  = r_rx;
                    w_rx_valid_nxt = 1'b1;
                    w_state_nxt    = GAP;
                end else begin
                    w_cnt_nxt = '0;
                    w_sck_nxt = 1'b1;
                    w_rx_nxt  = {r_rx[6:0], IO1_I};
                    w_bit_nxt = r_bit + 3'd1;
                end
            end

            GAP: begin
                if (w_cnt_done) begin
                    w_cnt_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    assign spi_tx_ready = r_ready;
    assign spi_rx_data  = r_rx_data;
    assign spi_rx_valid = r_rx_valid;
    assign SCK_O        = r_sck;
    assign SCK_T        = 1'b0;
    assign SS_O         = r_ss;
    assign SS_T         = 1'b0;
    assign IO0_O        = r_io0;
    assign IO0_T        = 1'b0;
    assign IO1_O        = 1'b0;
    assign IO1_T        = 1'b1;
endmodule

// File: tb/tb_spi_master_axis.sv
// Bench for spi_master_axis: three instances (CLK_RATIO 1, 2, 4) with MISO looped to MOSI.
module tb_spi_master_axis;
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [2:0][7:0] tx_data = '0;
    logic [2:0]      tx_valid = '0;
    wire  [2:0]      rdy, rxv, sck, ss, mosi, sck_t, ss_t, io0_t, io1_o, io1_t;
    wire  [2:0][7:0] rxd;

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_master_axis #(.CLK_RATIO(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk(clk), .rst(rst),
            .spi_tx_data(tx_data[g]), .spi_tx_valid(tx_valid[g]), .spi_tx_ready(rdy[g]),
            .spi_rx_data(rxd[g]), .spi_rx_valid(rxv[g]),
            .SCK_I(1'b0), .SCK_O(sck[g]), .SCK_T(sck_t[g]),
            .SS_I(1'b0), .SS_O(ss[g]), .SS_T(ss_t[g]),
            .IO0_I(1'b0), .IO0_O(mosi[g]), .IO0_T(io0_t[g]),
            .IO1_I(mosi[g]), .IO1_O(io1_o[g]), .IO1_T(io1_t[g])
        );
    end

    function automatic int rat(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    typedef struct {
        int         inst;
        logic [7:0] mosi;
        logic [7:0] rxd;
        logic       rxv;
        int         low;
        int         rise;
        int         pmin;
        int         pmax;
        int         gap;
    } frame_t;

    typedef struct {
        int         inst;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        int         exp_low;
        int         exp_lat;
        logic       exp_idle_mosi;
    } vec_t;

    // Monitor state (written only by the negedge monitor).
    int         cyc = 0;
    frame_t     act_arr[64];
    int         act_wr = 0;
    logic       prev_ss[3], prev_sck[3], prev_rdy[3], acc_pend[3], seen[3];
    int         acc_cyc[3], acc_cnt[3], lat_cnt[3], last_lat[3];
    int         cur_low[3], cur_rise[3], cur_gap[3], pmin[3], pmax[3], last_rise[3];
    int         ss_hi_run[3], rise_total[3], sck_hi_ss[3], stray[3];
    logic [7:0] cur_mosi[3];
    int         mon_per;

    // Checker state (written only by the stimulus process).
    int   n_checks = 0;
    int   n_fail = 0;
    int   act_rd = 0;
    exp_t exp_q[$];
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 3; i++) begin
            acc_cnt[i] = 0; lat_cnt[i] = 0; last_lat[i] = 0; rise_total[i] = 0;
            sck_hi_ss[i] = 0; stray[i] = 0; acc_cyc[i] = 0; cur_gap[i] = -1;
            pmin[i] = 0; pmax[i] = 0; last_rise[i] = -1; cur_mosi[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                prev_ss[i] = 1'b1; prev_sck[i] = 1'b0; prev_rdy[i] = 1'b0;
                acc_pend[i] = 1'b0; seen[i] = 1'b0; cur_low[i] = 0; cur_rise[i] = 0;
                ss_hi_run[i] = 0;
            end else begin
                if (tx_valid[i] && rdy[i]) begin
                    acc_cyc[i] = cyc + 1;
                    acc_pend[i] = 1'b1;
                    acc_cnt[i]++;
                end
                if (rdy[i] && !prev_rdy[i] && acc_pend[i]) begin
                    last_lat[i] = cyc - acc_cyc[i];
                    acc_pend[i] = 1'b0;
                    lat_cnt[i]++;
                end
                if (!ss[i] && prev_ss[i]) begin
                    cur_gap[i] = seen[i] ? ss_hi_run[i] : -1;
                    cur_low[i] = 0; cur_rise[i] = 0; cur_mosi[i] = '0;
                    pmin[i] = 1000; pmax[i] = 0; last_rise[i] = -1;
                end
                if (!ss[i]) cur_low[i]++;
                if (sck[i] && !prev_sck[i]) begin
                    rise_total[i]++;
                    cur_rise[i]++;
                    cur_mosi[i] = {cur_mosi[i][6:0], mosi[i]};
                    if (last_rise[i] >= 0) begin
                        mon_per = cyc - last_rise[i];
                        if (mon_per < pmin[i]) pmin[i] = mon_per;
                        if (mon_per > pmax[i]) pmax[i] = mon_per;
                    end
                    last_rise[i] = cyc;
                end
                if (sck[i] && ss[i]) sck_hi_ss[i]++;
                if (ss[i] && !prev_ss[i]) begin
                    act_arr[act_wr % 64] = '{i, cur_mosi[i], rxd[i], rxv[i], cur_low[i],
                                             cur_rise[i], pmin[i], pmax[i], cur_gap[i]};
                    act_wr++;
                    seen[i] = 1'b1;
                    ss_hi_run[i] = 1;
                    cur_rise[i] = 0;
                end else begin
                    if (ss[i]) ss_hi_run[i]++;
                    if (rxv[i]) stray[i]++;
                end
                prev_ss[i] = ss[i];
                prev_sck[i] = sck[i];
                prev_rdy[i] = rdy[i];
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_accept(input int i, input int a0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (acc_cnt[i] != a0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send(input int i, input logic [7:0] b, input bit keep, output bit ok);
        int a0;
        tx_data[i] = b;
        tx_valid[i] = 1'b1;
        a0 = acc_cnt[i];
        wait_accept(i, a0, ok);
        if (ok) exp_q.push_back('{i, b});
        if (!keep) tx_valid[i] = 1'b0;
    endtask

    task automatic check_frame(input int i, input int exp_low, output frame_t fo);
        exp_t e;
        fo = '{-1, 8'h00, 8'h00, 1'b0, 0, 0, 0, 0, -1};
        for (int k = 0; k < 600; k++) begin
            if (act_wr != act_rd) break;
            @(posedge clk); #1;
        end
        if (act_wr == act_rd) begin
            chk("frame_timeout", 0, 1);
            return;
        end
        fo = act_arr[act_rd % 64];
        act_rd++;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("frame_inst", fo.inst, i);
        chk("mosi_bits", fo.mosi, e.b);
        chk("rx_data", fo.rxd, e.b);
        chk("rx_valid_at_ss_rise", fo.rxv, 1);
        chk("ss_low_cycles", fo.low, exp_low);
        chk("sck_rises", fo.rise, 8);
        chk("sck_period_min", fo.pmin, 2 * rat(i));
        chk("sck_period_max", fo.pmax, 2 * rat(i));
    endtask

    task automatic wait_lat(input int i, input int l0, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (lat_cnt[i] != l0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    initial begin
        frame_t fo;
        bit     ok;
        int     l0, a0;

        vecs[0] = '{1, 8'h55, 8'h55, 34, 37, 1'b1};
        vecs[1] = '{0, 8'h3C, 8'h3C, 17, 19, 1'b0};
        vecs[2] = '{2, 8'h3C, 8'h3C, 68, 73, 1'b0};
        vecs[3] = '{1, 8'h00, 8'h00, 34, 37, 1'b0};
        vecs[4] = '{1, 8'hFF, 8'hFF, 34, 37, 1'b1};
        vecs[5] = '{1, 8'h81, 8'h81, 34, 37, 1'b1};

        // Reset held low, outputs at their reset values.
        #50;
        chk("rst_ready", rdy, 0);
        chk("rst_ss", ss, 3'b111);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx_valid", rxv, 0);
        chk("rst_rx_data", rxd, 0);
        #53 rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_ready", rdy, 3'b111);
        chk("post_rst_ss", ss, 3'b111);
        chk("post_rst_sck", sck, 0);
        chk("tie_sck_t", sck_t, 0);
        chk("tie_ss_t", ss_t, 0);
        chk("tie_io0_t", io0_t, 0);
        chk("tie_io1_o", io1_o, 0);
        chk("tie_io1_t", io1_t, 3'b111);
        repeat (20) begin @(posedge clk); #1; end
        chk("idle_sck_rises", rise_total[0] + rise_total[1] + rise_total[2], 0);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            l0 = lat_cnt[vecs[v].inst];
            send(vecs[v].inst, vecs[v].tx, 1'b0, ok);
            if (ok) begin
                check_frame(vecs[v].inst, vecs[v].exp_low, fo);
                chk("vec_rx", fo.rxd, vecs[v].exp_rx);
                wait_lat(vecs[v].inst, l0, ok);
                if (ok) chk("ready_latency", last_lat[vecs[v].inst], vecs[v].exp_lat);
                repeat (5) begin @(posedge clk); #1; end
                chk("rx_data_hold", rxd[vecs[v].inst], vecs[v].exp_rx);
                chk("mosi_idle_hold", mosi[vecs[v].inst], vecs[v].exp_idle_mosi);
            end
        end

        // Back-to-back with valid held; data changes right after first acceptance.
        send(1, 8'hA3, 1'b1, ok);
        send(1, 8'hAA, 1'b0, ok);
        check_frame(1, 34, fo);
        check_frame(1, 34, fo);
        chk("b2b_ss_gap_ge_ratio", (fo.gap >= 2) ? 1 : 0, 1);
        repeat (10) begin @(posedge clk); #1; end

        // New byte offered mid-frame waits until the gap ends and is sent intact.
        send(1, 8'h96, 1'b0, ok);
        repeat (10) begin @(posedge clk); #1; end
        a0 = acc_cnt[1];
        tx_data[1] = 8'h4B;
        tx_valid[1] = 1'b1;
        check_frame(1, 34, fo);
        chk("busy_no_accept", acc_cnt[1], a0);
        chk("busy_ready_low", rdy[1], 0);
        wait_accept(1, a0, ok);
        if (ok) exp_q.push_back('{1, 8'h4B});
        tx_valid[1] = 1'b0;
        check_frame(1, 34, fo);
        repeat (10) begin @(posedge clk); #1; end

        // Asynchronous reset after three SCK rising edges.
        send(1, 8'h5A, 1'b0, ok);
        for (int k = 0; k < 200; k++) begin
            if (cur_rise[1] >= 3) break;
            @(posedge clk); #1;
        end
        chk("abort_reached_3_edges", (cur_rise[1] >= 3) ? 1 : 0, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_ss", ss[1], 1);
        chk("abort_sck", sck[1], 0);
        chk("abort_ready", rdy[1], 0);
        chk("abort_rx_valid", rxv[1], 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        chk("abort_no_frame", act_wr - act_rd, 0);
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        l0 = lat_cnt[1];
        send(1, 8'hC3, 1'b0, ok);
        check_frame(1, 34, fo);
        wait_lat(1, l0, ok);
        if (ok) chk("post_abort_latency", last_lat[1], 37);

        repeat (10) begin @(posedge clk); #1; end
        chk("stray_rx_valid", stray[0] + stray[1] + stray[2], 0);
        chk("sck_high_while_ss_high", sck_hi_ss[0] + sck_hi_ss[1] + sck_hi_ss[2], 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master_axis.md
Name: spi_master_axis

Overview:
- Single-mode SPI master, mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first.
- Bytes to send arrive on an AXI-Stream-style valid/ready input; received bytes leave on a valid-only output.
- Pins are exposed as I/O/T triplets for connection to top-level tristate buffers. T=1 means high-Z.
- IO0 is MOSI and IO1 is MISO.

Parameters:
CLK_RATIO, 2, SCK half-period in clk cycles (integer >= 1); SCK frequency = clk / (2*CLK_RATIO).

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
spi_tx_data  in  8  byte to transmit
spi_tx_valid  in  1  tx_data valid
spi_tx_ready  out  1  block can accept a byte; transfer when valid & ready on a clk edge
spi_rx_data  out  8  last received byte
spi_rx_valid  out  1  one-cycle pulse, rx_data updated
SCK_I  in  1  unused
SCK_O  out  1  serial clock
SCK_T  out  1  tie 0 (always driven)
SS_I  in  1  unused
SS_O  out  1  slave select, active low
SS_T  out  1  tie 0
IO0_I  in  1  unused
IO0_O  out  1  MOSI
IO0_T  out  1  tie 0
IO1_I  in  1  MISO
IO1_O  out  1  tie 0
IO1_T  out  1  tie 1 (input only)

Behaviour:
- Reset values: SCK_O=0, SS_O=1, IO0_O=0, spi_tx_ready=0, spi_rx_data=0, spi_rx_valid=0; internal state=IDLE.
- Reset asserted mid-frame aborts the frame immediately; no rx_valid is produced.
- All outputs are registered except the constant ties.
- States: IDLE, LEAD, SHIFT, GAP.
- IDLE:
  - spi_tx_ready=1.
  - On valid&ready: latch tx_data into the shift register and drop ready next cycle.
  - Next cycle: SS_O=0, IO0_O=bit7, go to LEAD.
- LEAD: SCK_O low for CLK_RATIO cycles, then go to SHIFT.
- SHIFT: 8 bits, each CLK_RATIO cycles SCK high then CLK_RATIO cycles SCK low.
  - On each SCK rising edge (the cycle SCK_O goes 1), sample IO1_I into the rx shift register (MSB first).
  - On each SCK falling edge, IO0_O advances to the next lower bit.
  - After bit0 the falling edge does not change IO0_O.
  - The 8th low phase is the SS hold time.
- End of SHIFT:
  - SS_O=1.
  - spi_rx_data = assembled byte.
  - spi_rx_valid=1 for exactly one cycle, in the same cycle SS_O rises.
  - Go to GAP.
- GAP: SS high and ready low for CLK_RATIO cycles, then IDLE with ready=1.
- Frame timing:
  - Exactly 8 SCK rising edges per frame.
  - Acceptance to next ready = 18*CLK_RATIO + 1 cycles.
  - SS low for 17*CLK_RATIO cycles.
- Back-to-back bytes: each byte is its own frame; SS always deasserts between bytes for at least CLK_RATIO cycles.
- tx_valid while busy: ready stays low; the byte waits upstream, not dropped.
- tx_data changes are ignored after acceptance.
- spi_rx_data holds its value until the next frame completes.
- SCK idles low; SCK_O never toggles while SS_O=1.
- IO0_O holds its last value between frames.

Test Plan:
- Reset held low 100 ns, then released; spi_tx_valid=0 -> SS_O=1, SCK_O=0, spi_tx_ready=1 after reset; no SCK edges.
- CLK_RATIO=2, IO1_I looped to IO0_O, send 0x55 -> SS low 34 cycles, 8 SCK rising edges with period 4 clk, MOSI 0,1,0,1,0,1,0,1 at rising edges, spi_rx_valid pulse with spi_rx_data=0x55.
- Send 0xA3 then 0xAA back-to-back (valid held) -> MOSI 1,0,1,0,0,0,1,1 then 1,0,1,0,1,0,1,0; SS high >= 2 cycles between frames; rx 0xA3 then 0xAA, one valid pulse each.
- During a frame, assert tx_valid with a new byte -> ready stays low until GAP ends; that byte is sent intact next frame.
- Pull rst low mid-frame (after 3 SCK edges) -> SS_O=1, SCK_O=0 asynchronously, no rx_valid; next byte after reset transfers correctly.
- CLK_RATIO=1 and CLK_RATIO=4 loopback of 0x3C -> SCK period 2 and 8 clk respectively, rx 0x3C, ready returns 19 and 73 cycles after acceptance.
